mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The module SHALL have no parameters; data width 32, register-address width 5.
REQ-002 The ports SHALL be as follows; any port not listed SHALL NOT exist:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; 0 freezes all state
- ex_rd_data  in  32  ALU result from ex_mem
- ex_rd_addr  in  5  destination register
- ex_rd_e  in  1  destination write enable
- ex_mem_op  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- ex_mem_addr  in  32  effective address
- ex_mem_wdata  in  32  store data
- stall_hold  in  1  downstream (mem_wb) stall; 1 means results not yet consumed
- mc_rdata  in  32  controller read data, right-aligned
- mc_done  in  1  controller completion pulse
- mc_req  out  1  access request, registered
- mc_we  out  1  1 store, 0 load, registered
- mc_addr  out  32  access address, registered
- mc_wdata  out  32  store data, registered
- mc_len  out  2  0 byte, 1 half, 3 word, registered
- mem_rd_data  out  32  result to mem_wb
- mem_rd_addr  out  5  destination to mem_wb
- mem_rd_e  out  1  write enable to mem_wb
- stall_req  out  1  pipeline stall request, combinational

Function
REQ-003 "Memory op" SHALL mean ex_mem_op in 1..8; FSM states SHALL be IDLE, BUSY, DONE.
REQ-004 IDLE, rdy=1, memory op present: the block SHALL register mc_req=1, mc_we (1 for ops 6-8), mc_addr=ex_mem_addr, mc_wdata=ex_mem_wdata, mc_len (LB/LBU/SB 0, LH/LHU/SH 1, LW/SW 3), and go to BUSY.
REQ-005 BUSY: mc_req and all mc_* outputs SHALL hold stable until mc_done=1 is sampled with rdy=1.
REQ-006 On mc_done in BUSY: result register SHALL capture the extended load value (stores: unchanged), mc_req SHALL go 0 at that edge, state SHALL go to DONE.
REQ-007 Extension: LB sign-extends mc_rdata[7:0]; LH sign-extends [15:0]; LBU/LHU zero-extend; LW uses all 32 bits.
REQ-008 DONE: stays while stall_hold=1; returns to IDLE at the first rdy=1 edge with stall_hold=0.
REQ-009 stall_req SHALL be 1 when a memory op is present and state is not DONE; 0 otherwise.
REQ-010 mem_rd_addr SHALL always equal ex_rd_addr.
REQ-011 mem_rd_data SHALL equal the result register when a load op is present, else ex_rd_data.
REQ-012 mem_rd_e SHALL equal ex_rd_e when stall_req=0, else 0.
REQ-013 Non-memory ops SHALL pass through with zero added latency and no mc_req.
REQ-014 Memory op latency: request issued 1 cycle after op presented; stall_req drops the cycle after mc_done.
REQ-015 mc_done SHALL be ignored in IDLE and DONE, and whenever rdy=0.
REQ-016 rdy=0 SHALL freeze the state and all registered outputs, including mc_req.
REQ-017 Addresses SHALL pass verbatim; no alignment check, no exception.

Reset
REQ-018 rst=1 at a posedge SHALL force: IDLE; mc_req=0, mc_we=0, mc_addr=0, mc_wdata=0, mc_len=0; result register 0. rst takes priority over rdy.
REQ-019 rst during BUSY SHALL abort the access; mc_req=0 from the next cycle, and any later mc_done SHALL be ignored.

Verification
REQ-020 Bench SHALL cover:
- op=NONE, ex_rd_data=0x1234, rd_addr=5, rd_e=1 -> same cycle mem_rd_data=0x1234, addr=5, e=1; stall_req=0; mc_req stays 0.
- LB at 0x100, mc_done after 3 cycles with mc_rdata=0x000000F0 -> mc_req=1, len=0, we=0; stall_req=1 for 4 cycles; DONE shows mem_rd_data=0xFFFFFFF0, rd_e=1.
- LHU, mc_rdata=0x0000_8001 -> 0x00008001; LH, same data -> 0xFFFF8001.
- SW addr 0x2000, wdata 0xDEADBEEF -> mc_we=1, mc_len=3, mc_addr=0x2000, mc_wdata=0xDEADBEEF; mc_done -> DONE, stall_req=0.
- LW with stall_hold=1 held 2 cycles in DONE -> state remains DONE, mem_rd_data stable, no new mc_req; releases to IDLE after stall_hold=0.
- rst asserted in BUSY, then mc_done pulse -> mc_req=0 after edge, state IDLE, pulse ignored; rdy=0 mid-BUSY -> all outputs frozen.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_stage                                                    |
// | Description : Pipeline memory stage; issues loads/stores to a memory       |
// |               controller, extends load data, and stalls the pipe meanwhile.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] ex_rd_data,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_rd_e,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_mem_wdata,
    input  logic        stall_hold,
    input  logic [31:0] mc_rdata,
    input  logic        mc_done,
    output logic        mc_req,
    output logic        mc_we,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_wdata,
    output logic [1:0]  mc_len,
    output logic [31:0] mem_rd_data,
    output logic [4:0]  mem_rd_addr,
    output logic        mem_rd_e,
    output logic        stall_req
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [3:0] c_OP_LB  = 4'd1;
    localparam logic [3:0] c_OP_LH  = 4'd2;
    localparam logic [3:0] c_OP_LW  = 4'd3;
    localparam logic [3:0] c_OP_LBU = 4'd4;
    localparam logic [3:0] c_OP_LHU = 4'd5;
    localparam logic [3:0] c_OP_SB  = 4'd6;
    localparam logic [3:0] c_OP_SH  = 4'd7;
    localparam logic [3:0] c_OP_SW  = 4'd8;

    localparam logic [1:0] c_LEN_BYTE = 2'd0;
    localparam logic [1:0] c_LEN_HALF = 2'd1;
    localparam logic [1:0] c_LEN_WORD = 2'd3;

    logic [1:0]  r_state;
    logic [3:0]  r_op;
    logic        r_mc_req;
    logic        r_mc_we;
    logic [31:0] r_mc_addr;
    logic [31:0] r_mc_wdata;
    logic [1:0]  r_mc_len;
    logic [31:0] r_result;

    logic        w_is_mem;
    logic        w_is_load;
    logic        w_is_store;
    logic [1:0]  w_len;
    logic [31:0] w_load_val;

    always_comb begin
        w_is_mem   = (ex_mem_op >= c_OP_LB) && (ex_mem_op <= c_OP_SW);
        w_is_load  = (ex_mem_op >= c_OP_LB) && (ex_mem_op <= c_OP_LHU);
        w_is_store = (ex_mem_op >= c_OP_SB) && (ex_mem_op <= c_OP_SW);
        case (ex_mem_op)
            c_OP_LB, c_OP_LBU, c_OP_SB: w_len = c_LEN_BYTE;
            c_OP_LH, c_OP_LHU, c_OP_SH: w_len = c_LEN_HALF;
            default:                    w_len = c_LEN_WORD;
        endcase
    end

    // Extension keys off the op captured at issue, not the live pipeline input.
    always_comb begin
        case (r_op)
            c_OP_LB:  w_load_val = {{24{mc_rdata[7]}}, mc_rdata[7:0]};
            c_OP_LH:  w_load_val = {{16{mc_rdata[15]}}, mc_rdata[15:0]};
            c_OP_LBU: w_load_val = {24'd0, mc_rdata[7:0]};
            c_OP_LHU: w_load_val = {16'd0, mc_rdata[15:0]};
            default:  w_load_val = mc_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_op       <= 4'd0;
            r_mc_req   <= 1'b0;
            r_mc_we    <= 1'b0;
            r_mc_addr  <= 32'd0;
            r_mc_wdata <= 32'd0;
            r_mc_len   <= 2'd0;
            r_result   <= 32'd0;
        end else if (rdy) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_is_mem) begin
                        r_op       <= ex_mem_op;
                        r_mc_req   <= 1'b1;
                        r_mc_we    <= w_is_store;
                        r_mc_addr  <= ex_mem_addr;
                        r_mc_wdata <= ex_mem_wdata;
                        r_mc_len   <= w_len;
                        r_state    <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (mc_done) begin
                        r_mc_req <= 1'b0;
                        if (r_op <= c_OP_LHU) begin
                            r_result <= w_load_val;
                        end
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (!stall_hold) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign mc_req      = r_mc_req;
    assign mc_we       = r_mc_we;
    assign mc_addr     = r_mc_addr;
    assign mc_wdata    = r_mc_wdata;
    assign mc_len      = r_mc_len;

    assign stall_req   = w_is_mem && (r_state != c_ST_DONE);
    assign mem_rd_addr = ex_rd_addr;
    assign mem_rd_data = w_is_load ? r_result : ex_rd_data;
    assign mem_rd_e    = stall_req ? 1'b0 : ex_rd_e;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_stage                                                 |
// | Description : Scoreboard bench for mem_stage with a memory-controller model|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [31:0] ex_rd_data, ex_mem_addr, ex_mem_wdata, mc_rdata;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_e, stall_hold, mc_done;
    logic [3:0]  ex_mem_op;
    logic        mc_req, mc_we, mem_rd_e, stall_req;
    logic [31:0] mc_addr, mc_wdata, mem_rd_data;
    logic [1:0]  mc_len;
    logic [4:0]  mem_rd_addr;
    logic        tb_valid;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  len;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        e;
        int          stalls;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   stall_cnt = 0;

    mem_stage dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ex_rd_data(ex_rd_data), .ex_rd_addr(ex_rd_addr), .ex_rd_e(ex_rd_e),
        .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_wdata(ex_mem_wdata),
        .stall_hold(stall_hold), .mc_rdata(mc_rdata), .mc_done(mc_done),
        .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_len(mc_len), .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr),
        .mem_rd_e(mem_rd_e), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: access size in bytes, and load value via plain arithmetic.
    function automatic int access_bytes(input logic [3:0] op);
        if (op == 1 || op == 4 || op == 6) return 1;
        if (op == 2 || op == 5 || op == 7) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_value(input logic [3:0] op, input logic [31:0] raw);
        longint v;
        longint span;
        v    = raw;
        span = longint'(1) << (8 * access_bytes(op));
        if (op != 3) begin
            v = v % span;
            if ((op == 1 || op == 2) && v >= span / 2) v = v - span;
        end
        return v[31:0];
    endfunction

    // Monitor: request stream and retired results checked against the queues.
    logic prev_req = 1'b0;
    req_t cur_req;
    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0;
        end else begin
            if (mc_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_mc_req", 32'd1, 32'd0);
                    cur_req = '{we: mc_we, addr: mc_addr, wdata: mc_wdata, len: mc_len};
                end else begin
                    cur_req = req_q.pop_front();
                end
            end
            if (mc_req) begin
                chk("mc_we",    {31'd0, mc_we}, {31'd0, cur_req.we});
                chk("mc_addr",  mc_addr,        cur_req.addr);
                chk("mc_wdata", mc_wdata,       cur_req.wdata);
                chk("mc_len",   {30'd0, mc_len}, {30'd0, cur_req.len});
            end
            if (tb_valid) begin
                if (stall_req) begin
                    stall_cnt++;
                    chk("rd_e_while_stalled", {31'd0, mem_rd_e}, 32'd0);
                end else if (res_q.size() == 0) begin
                    chk("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    chk("mem_rd_data", mem_rd_data,         res_q[0].data);
                    chk("mem_rd_addr", {27'd0, mem_rd_addr}, {27'd0, res_q[0].addr});
                    chk("mem_rd_e",    {31'd0, mem_rd_e},    {31'd0, res_q[0].e});
                    if (!stall_hold && rdy) begin
                        chk("stall_cycles", stall_cnt, res_q[0].stalls);
                        void'(res_q.pop_front());
                        stall_cnt = 0;
                    end
                end
            end
        end
        prev_req = mc_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic recover();
        rst = 1'b1; ex_mem_op = 4'd0; tb_valid = 1'b0; mc_done = 1'b0; rdy = 1'b1; stall_hold = 1'b0;
        tick();
        rst = 1'b0;
        req_q.delete();
        res_q.delete();
    endtask

    task automatic run_plain(input logic [3:0] op, input logic [31:0] d, input logic [4:0] a, input logic e);
        res_t x;
        ex_mem_op = op; ex_rd_data = d; ex_rd_addr = a; ex_rd_e = e;
        ex_mem_addr = $urandom; ex_mem_wdata = $urandom;
        stall_hold = 1'b0; mc_done = 1'b0; rdy = 1'b1;
        x.data = d; x.addr = a; x.e = e; x.stalls = 0;
        res_q.push_back(x);
        tb_valid = 1'b1;
        tick();
    endtask

    task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd_data, input logic [4:0] rd_addr, input logic rd_e,
                           input logic [31:0] rdata, input int delay, input int gap, input int hold);
        req_t r;
        res_t x;
        int   k;
        r.we = (op >= 6); r.addr = addr; r.wdata = wdata;
        r.len = 2'(access_bytes(op) - 1);
        req_q.push_back(r);
        x.data = (op <= 5) ? load_value(op, rdata) : rd_data;
        x.addr = rd_addr; x.e = rd_e; x.stalls = 2 + delay + gap;
        res_q.push_back(x);
        ex_mem_op = op; ex_mem_addr = addr; ex_mem_wdata = wdata;
        ex_rd_data = rd_data; ex_rd_addr = rd_addr; ex_rd_e = rd_e;
        stall_hold = 1'b0; mc_done = 1'b0; rdy = 1'b1; mc_rdata = $urandom;
        tb_valid = 1'b1;
        tick();
        k = 0;
        while (!mc_req && k < 8) begin
            tick();
            k++;
        end
        chk("req_issued", {31'd0, mc_req}, 32'd1);
        if (!mc_req) begin
            recover();
            return;
        end
        repeat (delay) tick();
        repeat (gap) begin
            rdy = 1'b0; mc_done = 1'($urandom_range(0, 1)); mc_rdata = $urandom;
            tick();
        end
        rdy = 1'b1; mc_done = 1'b1; mc_rdata = rdata;
        tick();
        mc_done = 1'b0; mc_rdata = $urandom;
        stall_hold = (hold > 0);
        repeat (hold) tick();
        stall_hold = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b0; tb_valid = 1'b0; stall_hold = 1'b0;
        mc_done = 1'b0; mc_rdata = 32'd0;
        ex_mem_op = 4'd1; ex_rd_data = 32'hA5A5A5A5; ex_rd_addr = 5'd7; ex_rd_e = 1'b1;
        ex_mem_addr = 32'h44; ex_mem_wdata = 32'h55;
        tick();
        tick();
        chk("rst_mc_req",   {31'd0, mc_req}, 32'd0);
        chk("rst_mc_we",    {31'd0, mc_we},  32'd0);
        chk("rst_mc_addr",  mc_addr,         32'd0);
        chk("rst_mc_wdata", mc_wdata,        32'd0);
        chk("rst_mc_len",   {30'd0, mc_len}, 32'd0);
        chk("rst_result",   mem_rd_data,     32'd0);
        chk("rst_stall",    {31'd0, stall_req}, 32'd1);
        chk("rst_rd_e",     {31'd0, mem_rd_e},  32'd0);
        chk("rst_rd_addr",  {27'd0, mem_rd_addr}, 32'd7);
        ex_mem_op = 4'd0; rdy = 1'b1;
        tick();
        rst = 1'b0;

        run_plain(4'd0, 32'h1234, 5'd5, 1'b1);
        run_mem(4'd1, 32'h100, 32'h0, 32'h1111, 5'd3, 1'b1, 32'h000000F0, 2, 0, 0);
        run_mem(4'd5, 32'h204, 32'h0, 32'h2222, 5'd4, 1'b1, 32'h00008001, 1, 0, 0);
        run_mem(4'd2, 32'h206, 32'h0, 32'h3333, 5'd6, 1'b1, 32'h00008001, 0, 0, 0);
        run_mem(4'd8, 32'h2000, 32'hDEADBEEF, 32'h4444, 5'd0, 1'b0, 32'h0, 1, 0, 0);
        run_mem(4'd3, 32'h300, 32'h0, 32'h5555, 5'd9, 1'b1, 32'h89ABCDEF, 1, 0, 2);

        // Abort an in-flight access with reset, then show the late done pulse is ignored.
        begin
            req_t r;
            r.we = 1'b0; r.addr = 32'h400; r.wdata = 32'h0; r.len = 2'd3;
            req_q.push_back(r);
            ex_mem_op = 4'd3; ex_mem_addr = 32'h400; ex_mem_wdata = 32'h0;
            ex_rd_data = 32'h6666; tb_valid = 1'b0;
            tick();
            tick();
            rst = 1'b1; ex_mem_op = 4'd0;
            tick();
            rst = 1'b0;
            chk("abort_mc_req", {31'd0, mc_req}, 32'd0);
            mc_done = 1'b1; mc_rdata = 32'h77777777;
            tick();
            mc_done = 1'b0;
            chk("abort_ignored_req", {31'd0, mc_req}, 32'd0);
            chk("abort_passthru", mem_rd_data, 32'h6666);
        end
        run_mem(4'd3, 32'h500, 32'h0, 32'h7777, 5'd1, 1'b1, 32'h0BADF00D, 1, 2, 0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op >= 1 && op <= 8)
                run_mem(op, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
                        $urandom, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
            else
                run_plain(op, $urandom, 5'($urandom), 1'($urandom));
        end

        tb_valid = 1'b0; ex_mem_op = 4'd0;
        tick();
        tick();
        chk("req_q_drained", req_q.size(), 32'd0);
        chk("res_q_drained", res_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
